// File: rtl/cam_capture_writer.sv
// OV7670 YUV422 capture: keeps luma bytes, decimates the frame to OUT_W x OUT_H
// and writes it into the frame buffer in raster order, all in the PCLK domain.
module cam_capture_writer #(
    parameter int OUT_W   = 64,
    parameter int OUT_H   = 64,
    parameter int DEC_X   = 10,
    parameter int DEC_Y   = 7,
    parameter int Y_FIRST = 1
) (
    input  logic        clka,
    input  logic        rst_n,
    input  logic        capture_en,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_d,
    output logic [14:0] addra,
    output logic [7:0]  din,
    output logic        wea,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int COL_W = $clog2(OUT_W + 1);
    localparam int ROW_W = $clog2(OUT_H + 1);
    localparam int XD_W  = $clog2(DEC_X + 1);
    localparam int YD_W  = $clog2(DEC_Y + 1);
    localparam logic Y_PHASE = (Y_FIRST != 0) ? 1'b0 : 1'b1;

    typedef enum logic [1:0] {
        S_WAIT_VS,
        S_VBLANK,
        S_ACTIVE
    } state_t;

    state_t            state_q, state_d;
    logic              vsync_q, href_q;
    logic              vsync_prev_q, href_prev_q;
    logic [7:0]        d_q;
    logic              phase_q, phase_d;
    logic [XD_W-1:0]   xdec_q, xdec_d;
    logic [YD_W-1:0]   ydec_q, ydec_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [14:0]       addra_q, addra_d;
    logic [7:0]        din_q, din_d;
    logic              wea_q, wea_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic              vs_rise, vs_fall, h_rise, h_fall;
    logic              cur_phase, keep;
    logic [14:0]       wr_addr;

    // Camera bus is sampled once; all edge detection uses the registered copies.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            d_q          <= 8'd0;
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
        end else begin
            vsync_q      <= cam_vsync;
            href_q       <= cam_href;
            d_q          <= cam_d;
            vsync_prev_q <= vsync_q;
            href_prev_q  <= href_q;
        end
    end

    assign vs_rise   = vsync_q & ~vsync_prev_q;
    assign vs_fall   = ~vsync_q & vsync_prev_q;
    assign h_rise    = href_q & ~href_prev_q;
    assign h_fall    = ~href_q & href_prev_q;
    assign cur_phase = h_rise ? 1'b0 : phase_q;
    assign wr_addr   = 15'(row_q) * 15'(OUT_W) + 15'(col_q);

    // Writes are suppressed on the vsync rise so wea never coincides with frame_done.
    assign keep = (state_q == S_ACTIVE) && !vs_rise && href_q && (cur_phase == Y_PHASE) &&
                  (xdec_q == '0) && (ydec_q == '0) &&
                  (col_q < COL_W'(OUT_W)) && (row_q < ROW_W'(OUT_H));

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        xdec_d       = xdec_q;
        ydec_d       = ydec_q;
        col_d        = col_q;
        row_d        = row_q;
        addra_d      = addra_q;
        din_d        = din_q;
        wea_d        = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        if (href_q) begin
            phase_d = ~cur_phase;
        end

        case (state_q)
            S_WAIT_VS: begin
                if (vsync_q) begin
                    state_d = S_VBLANK;
                end
            end
            S_VBLANK: begin
                if (vs_fall && capture_en) begin
                    state_d = S_ACTIVE;
                    busy_d  = 1'b1;
                    xdec_d  = '0;
                    ydec_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_ACTIVE: begin
                if (vs_rise) begin
                    state_d      = S_VBLANK;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                end else begin
                    if (keep) begin
                        wea_d   = 1'b1;
                        din_d   = d_q;
                        addra_d = wr_addr;
                        col_d   = col_q + 1'b1;
                    end
                    if (href_q && cur_phase) begin
                        xdec_d = (xdec_q == XD_W'(DEC_X - 1)) ? '0 : xdec_q + 1'b1;
                    end
                    // Row and col saturate at the output size so surplus pixels are dropped.
                    if (h_fall) begin
                        xdec_d = '0;
                        col_d  = '0;
                        ydec_d = (ydec_q == YD_W'(DEC_Y - 1)) ? '0 : ydec_q + 1'b1;
                        if ((ydec_q == '0) && (row_q < ROW_W'(OUT_H))) begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_WAIT_VS;
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_WAIT_VS;
            phase_q      <= 1'b0;
            xdec_q       <= '0;
            ydec_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            addra_q      <= 15'd0;
            din_q        <= 8'd0;
            wea_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            xdec_q       <= xdec_d;
            ydec_q       <= ydec_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addra_q      <= addra_d;
            din_q        <= din_d;
            wea_q        <= wea_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign addra      = addra_q;
    assign din        = din_q;
    assign wea        = wea_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cam_capture_writer.sv
// Drives two writer instances (default geometry and a small Y_FIRST=0 one) from one
// camera bus and checks every write, hold value and frame_done against a frame model.
module tb_cam_capture_writer;

    typedef struct {
        int addr;
        int data;
        int t;
    } wr_t;

    typedef struct {
        int t;
        int cnt;
    } fd_t;

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic        capture_en = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_d = 8'd0;

    logic [14:0] addra_a, addra_b;
    logic [7:0]  din_a, din_b;
    logic        wea_a, wea_b;
    logic        busy_a, busy_b;
    logic        frame_done_a, frame_done_b;
    logic [7:0]  frame_cnt_a, frame_cnt_b;

    int          vectors = 0;
    int          miscompares = 0;
    int          ncnt = 0;
    wr_t         exp_a[$];
    wr_t         exp_b[$];
    fd_t         fdq_a[$];
    fd_t         fdq_b[$];
    int          last_addr[2];
    int          last_din[2];
    int          writes[2];
    int          fd_seen[2];
    logic [7:0]  mem_a[4096];
    int          model_cnt = 0;
    bit          armed = 1'b0;
    bit          captured = 1'b0;

    always #5 clka = ~clka;

    cam_capture_writer dut_a (
        .clka(clka), .rst_n(rst_n), .capture_en(capture_en),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
        .addra(addra_a), .din(din_a), .wea(wea_a), .busy(busy_a),
        .frame_done(frame_done_a), .frame_cnt(frame_cnt_a)
    );

    cam_capture_writer #(.OUT_W(4), .OUT_H(2), .DEC_X(2), .DEC_Y(2), .Y_FIRST(0)) dut_b (
        .clka(clka), .rst_n(rst_n), .capture_en(capture_en),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
        .addra(addra_b), .din(din_b), .wea(wea_b), .busy(busy_b),
        .frame_done(frame_done_b), .frame_cnt(frame_cnt_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, expv, expv, $time);
        end
    endtask

    // Decimation rule for each instance: returns whether pixel p of line l is stored, and where.
    function automatic bit keep_pixel(input int di, input int l, input int p, output int addr);
        int ow, oh, dx, dy;
        if (di == 0) begin
            ow = 64; oh = 64; dx = 10; dy = 7;
        end else begin
            ow = 4; oh = 2; dx = 2; dy = 2;
        end
        addr = (l / dy) * ow + p / dx;
        return (p % dx == 0) && (l % dy == 0) && (p / dx < ow) && (l / dy < oh);
    endfunction

    function automatic logic [7:0] gen_byte(input int mode, input int b);
        case (mode)
            1:       return (b % 2 == 0) ? 8'((b / 2) % 256) : 8'h80;
            2:       return (b % 2 == 0) ? 8'h80 : 8'h33;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic step(input logic v, input logic h, input logic [7:0] d);
        @(posedge clka);
        #1;
        cam_vsync = v;
        cam_href  = h;
        cam_d     = d;
    endtask

    task automatic monitor(input int di, input logic w, input logic [14:0] a, input logic [7:0] d,
                           input logic fd, input logic [7:0] c);
        wr_t e;
        fd_t f;
        int  qs;
        if (w) begin
            qs = (di == 0) ? exp_a.size() : exp_b.size();
            if (qs == 0) begin
                checkOutput($sformatf("dut%0d unexpected wea addr=%0d", di, a), 32'd1, 32'd0);
            end else begin
                if (di == 0) e = exp_a.pop_front();
                else         e = exp_b.pop_front();
                checkOutput($sformatf("dut%0d addra", di), 32'(a), 32'(e.addr));
                checkOutput($sformatf("dut%0d din", di), 32'(d), 32'(e.data));
                checkOutput($sformatf("dut%0d write latency", di), 32'(ncnt), 32'(e.t));
                last_addr[di] = e.addr;
                last_din[di]  = e.data;
                writes[di]++;
                if (di == 0) mem_a[a[11:0]] = d;
            end
        end else begin
            checkOutput($sformatf("dut%0d addra hold", di), 32'(a), 32'(last_addr[di]));
            checkOutput($sformatf("dut%0d din hold", di), 32'(d), 32'(last_din[di]));
        end
        if (fd) begin
            fd_seen[di]++;
            checkOutput($sformatf("dut%0d wea with frame_done", di), 32'(w), 32'd0);
            qs = (di == 0) ? fdq_a.size() : fdq_b.size();
            if (qs == 0) begin
                checkOutput($sformatf("dut%0d unexpected frame_done", di), 32'd1, 32'd0);
            end else begin
                if (di == 0) f = fdq_a.pop_front();
                else         f = fdq_b.pop_front();
                checkOutput($sformatf("dut%0d frame_done time", di), 32'(ncnt), 32'(f.t));
                checkOutput($sformatf("dut%0d frame_cnt at done", di), 32'(c), 32'(f.cnt));
            end
        end
    endtask

    always @(negedge clka) begin
        ncnt++;
        if (rst_n) begin
            monitor(0, wea_a, addra_a, din_a, frame_done_a, frame_cnt_a);
            monitor(1, wea_b, addra_b, din_b, frame_done_b, frame_cnt_b);
        end
    end

    // One camera frame: blanking with stray HREF, then nl lines of w pixels (2 bytes each).
    task automatic applyStimulus(input int w, input int nl, input bit cap, input int drop_line,
                                 input int rst_line, input int mode);
        logic [7:0] b8;
        int         addr;
        for (int i = 0; i < 6; i++) step(1'b1, (i == 2 || i == 3), 8'($urandom));
        armed = 1'b1;
        capture_en = cap;
        step(1'b0, 1'b0, 8'd0);
        captured = armed && cap;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0);
        for (int l = 0; l < nl; l++) begin
            if (l == drop_line) capture_en = 1'b0;
            for (int b = 0; b < 2 * w; b++) begin
                b8 = gen_byte(mode, b);
                step(1'b0, 1'b1, b8);
                if (l == rst_line && b == w) begin
                    rst_n = 1'b0;
                    exp_a.delete(); exp_b.delete();
                    fdq_a.delete(); fdq_b.delete();
                    model_cnt = 0;
                    captured = 1'b0;
                    armed = 1'b0;
                    last_addr[0] = 0; last_addr[1] = 0;
                    last_din[0] = 0;  last_din[1] = 0;
                end
                if (l == rst_line && b == w + 2) begin
                    rst_n = 1'b1;
                    checkOutput("rst frame_cnt a", 32'(frame_cnt_a), 32'd0);
                    checkOutput("rst busy b", 32'(busy_b), 32'd0);
                    checkOutput("rst wea a", 32'(wea_a), 32'd0);
                end
                if (captured) begin
                    for (int di = 0; di < 2; di++) begin
                        if ((b % 2) == di && keep_pixel(di, l, b / 2, addr)) begin
                            if (di == 0) exp_a.push_back('{addr, int'(b8), ncnt + 3});
                            else         exp_b.push_back('{addr, int'(b8), ncnt + 3});
                        end
                    end
                end
            end
            for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd0);
        end
        checkOutput("busy during frame a", 32'(busy_a), 32'(captured));
        checkOutput("busy during frame b", 32'(busy_b), 32'(captured));
        step(1'b1, 1'b0, 8'd0);
        if (captured) begin
            model_cnt++;
            fdq_a.push_back('{ncnt + 3, model_cnt % 256});
            fdq_b.push_back('{ncnt + 3, model_cnt % 256});
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0);
        checkOutput("busy after frame a", 32'(busy_a), 32'd0);
        checkOutput("pending writes a", 32'(exp_a.size()), 32'd0);
        checkOutput("pending writes b", 32'(exp_b.size()), 32'd0);
        checkOutput("pending frame_done", 32'(fdq_a.size() + fdq_b.size()), 32'd0);
        checkOutput("frame_cnt a", 32'(frame_cnt_a), 32'(model_cnt % 256));
        checkOutput("frame_cnt b", 32'(frame_cnt_b), 32'(model_cnt % 256));
        capture_en = 1'b1;
        exp_a.delete(); exp_b.delete();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wa, wb, fa, fb;
        last_addr[0] = 0; last_addr[1] = 0;
        last_din[0] = 0;  last_din[1] = 0;
        writes[0] = 0;    writes[1] = 0;
        fd_seen[0] = 0;   fd_seen[1] = 0;
        for (int i = 0; i < 4096; i++) mem_a[i] = 8'hxx;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0);
        checkOutput("reset addra a", 32'(addra_a), 32'd0);
        checkOutput("reset din a", 32'(din_a), 32'd0);
        checkOutput("reset wea a", 32'(wea_a), 32'd0);
        checkOutput("reset busy a", 32'(busy_a), 32'd0);
        checkOutput("reset frame_done a", 32'(frame_done_a), 32'd0);
        checkOutput("reset frame_cnt a", 32'(frame_cnt_a), 32'd0);
        checkOutput("reset addra b", 32'(addra_b), 32'd0);
        checkOutput("reset wea b", 32'(wea_b), 32'd0);
        checkOutput("reset frame_cnt b", 32'(frame_cnt_b), 32'd0);
        rst_n = 1'b1;
        capture_en = 1'b1;

        // Full-width default frame, 15 lines (ends early), capture_en dropped mid-frame.
        wa = writes[0]; wb = writes[1];
        applyStimulus(640, 15, 1'b1, 8, -1, 1);
        checkOutput("wide frame writes a", 32'(writes[0] - wa), 32'd192);
        checkOutput("wide frame writes b", 32'(writes[1] - wb), 32'd8);
        checkOutput("din at addra 1", 32'(mem_a[1]), 32'd10);
        checkOutput("din at addra 63", 32'(mem_a[63]), 32'd118);
        checkOutput("din at addra 191", 32'(mem_a[191]), 32'd118);

        // capture_en low at frame start: nothing written, count unchanged.
        wa = writes[0]; wb = writes[1];
        applyStimulus(16, 6, 1'b0, -1, -1, 0);
        checkOutput("disabled writes a", 32'(writes[0] - wa), 32'd0);
        checkOutput("disabled writes b", 32'(writes[1] - wb), 32'd0);

        // U=0x80 / Y=0x33 stream: the Y_FIRST=0 instance must store only 0x33.
        wb = writes[1];
        applyStimulus(12, 5, 1'b1, -1, -1, 2);
        checkOutput("uy frame writes b", 32'(writes[1] - wb), 32'd8);

        for (int n = 0; n < 30; n++) begin
            applyStimulus($urandom_range(1, 24), $urandom_range(1, 8),
                          ($urandom_range(0, 3) != 0), $urandom_range(0, 9), -1, $urandom_range(0, 2));
        end

        // Reset in the middle of a line: the rest of that frame is ignored.
        wa = writes[0]; wb = writes[1];
        applyStimulus(8, 4, 1'b1, -1, 1, 0);
        checkOutput("post-reset frame_cnt a", 32'(frame_cnt_a), 32'd0);
        checkOutput("post-reset frame_cnt b", 32'(frame_cnt_b), 32'd0);

        // 256 captured frames bring frame_cnt back round to zero.
        fa = fd_seen[0]; fb = fd_seen[1];
        for (int n = 0; n < 256; n++) applyStimulus(4, 4, 1'b1, -1, -1, 0);
        checkOutput("wrap frame_done a", 32'(fd_seen[0] - fa), 32'd256);
        checkOutput("wrap frame_done b", 32'(fd_seen[1] - fb), 32'd256);
        checkOutput("wrap frame_cnt a", 32'(frame_cnt_a), 32'd0);
        checkOutput("wrap frame_cnt b", 32'(frame_cnt_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cam_capture_writer.md
Name: cam_capture_writer

Overview:
Camera-side writer for the frame buffer. It samples the OV7670 parallel bus (VSYNC, HREF, D[7:0]) in YUV422 mode and keeps only the luma (Y) bytes. It decimates the VGA frame down to OUT_W x OUT_H and drives the write port of the frame buffer (addra/din/wea) in raster order. It runs in the camera pixel-clock domain; the display side reads the frame buffer independently.

Parameters:
OUT_W, 64, stored columns per frame
OUT_H, 64, stored rows per frame (OUT_W*OUT_H <= 32768; default fills 4096 entries)
DEC_X, 10, keep 1 of every DEC_X pixels horizontally
DEC_Y, 7, keep 1 of every DEC_Y lines vertically
Y_FIRST, 1, 1 = byte order Y,U/V per pixel (Y is even byte); 0 = U/V,Y (Y is odd byte)

Ports:
clka  in  1  camera PCLK; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
capture_en  in  1  arm capture; sampled only at frame start
cam_vsync  in  1  camera VSYNC, high = vertical blank
cam_href  in  1  camera HREF, high = active line bytes
cam_d  in  8  camera data byte
addra  out  15  frame buffer write address
din  out  8  frame buffer write data (Y byte)
wea  out  1  frame buffer write enable, one-cycle pulses
busy  out  1  high while a frame is being captured
frame_done  out  1  one-cycle pulse when a captured frame completes
frame_cnt  out  8  count of completed captured frames, wraps 255->0

Behaviour:
- Reset (async, rst_n=0): state=S_WAIT_VS; addra=0, din=0, wea=0, busy=0, frame_done=0, frame_cnt=0; all counters cleared. Reset mid-frame abandons the frame with no further writes and no frame_done.
- The camera inputs are registered once (vsync_q, href_q, d_q). Edges are detected on the registered copies.
- FSM:
  - S_WAIT_VS: wait for vsync_q=1, then go to S_VBLANK. This ensures a partial frame after reset is never captured.
  - S_VBLANK: on the vsync_q falling edge, go to S_ACTIVE if capture_en=1 (busy<=1, clear row/col/line/pixel counters); otherwise stay in S_VBLANK.
  - S_ACTIVE: on the vsync_q rising edge, pulse frame_done=1 for one cycle, increment frame_cnt, set busy<=0, go to S_VBLANK.
- Deasserting capture_en mid-frame has no effect; the current frame completes.
- Byte phase: a toggle clears on every href_q rising edge and flips on each cycle with href_q=1. The Y byte is phase 0 when Y_FIRST=1, phase 1 otherwise. The pixel counter px increments after each phase-1 byte.
- Line counter ln increments on each href_q falling edge during S_ACTIVE; px clears at the same time.
- Decimation: counters xdec (0..DEC_X-1) and ydec (0..DEC_Y-1) advance with px and ln.
- A Y byte is kept only when all of the following hold: xdec=0, ydec=0, col<OUT_W, row<OUT_H. col increments per kept pixel and clears at line end. row increments at the end of a line in which ydec was 0. Pixels or lines beyond OUT_W/OUT_H are dropped, never wrapped.
- Write timing: registered outputs. In the cycle after a kept Y byte is in d_q: wea=1, din=that byte, addra=row*OUT_W+col (computed at the width of addra, no truncation at defaults). Otherwise wea=0, while addra and din hold their last values.
- Latency: a cam_d byte reaches din 2 clka cycles after being presented (input register + output register).
- Defaults on 640x480 input: kept x = 0,10,...,630 (64 columns); kept lines = 0,7,...,441 (64 rows); the last write is at addra=4095. Lines 448..479 are dropped.
- A frame that ends early (vsync rises before OUT_H rows) still pulses frame_done; unwritten addresses keep their old contents.
- HREF asserted while in S_VBLANK/S_WAIT_VS is ignored. frame_done and wea never assert in the same cycle.

Test Plan:
- Reset mid-line: assert rst_n=0 during HREF, release -> wea=0 until the next full vsync high-then-low; no frame_done for the abandoned frame.
- Full default frame (640x480, Y_FIRST=1, Y byte = column index mod 256): exactly 4096 wea pulses; addra runs 0..4095 in order; din at addra=1 is 10 and at addra=63 is 630 mod 256 = 118; one frame_done; frame_cnt=1.
- capture_en=0 at vsync fall -> zero writes, busy=0, frame_cnt unchanged. capture_en dropped mid-frame -> frame completes with 4096 writes.
- Y_FIRST=0 with cam_d pattern U=0x80, Y=0x33 -> every din=0x33, never 0x80.
- Short frame: vsync rises after 100 lines -> 15 rows written (addra max 14*64+63=959), frame_done pulses once.
- frame_cnt wrap: 256 captured frames (reduced size OUT_W=4, OUT_H=2, small input) -> frame_cnt returns to 0 with 256 frame_done pulses.
